uart_tx: RTL and testbench

Byte-serial UART transmitter, the transmit-side counterpart of `uart_rx`. It accepts one byte per valid/ready handshake and shifts it onto `tx` as a start bit, 8 data bits LSB first, an optional parity bit, and stop bits. Each bit lasts a programmable number of `clk` cycles. The default configuration matches `uart_rx` framing (one bit per clock) so the two can be looped back directly.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, data width, line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int UART_DATA_BITS = 8;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter; tick marks the last clk cycle of each serial bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: start, 8 data bits LSB first, stop bits.
// Define UART_TX_PARITY_EN to add a parity bit after D7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 2,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam logic [2:0] LAST_IDX  = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                    state, state_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic [2:0]                idx, idx_n;
    logic                      stop_cnt, stop_cnt_n;
    logic                      tx_n;
    logic                      tick;
    logic                      accept;
    logic                      last_stop;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    logic par, par_n;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .tick(tick)
    );

    // Accepting in the final stop cycle chains frames with no idle gap.
    assign last_stop = (state == STOP) && tick && (stop_cnt == LAST_STOP);
    assign ready     = (state == IDLE) || last_stop;
    assign accept    = valid && ready;

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        idx_n      = idx;
        stop_cnt_n = stop_cnt;
        tx_n       = tx;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        if (accept) begin
            state_n    = START;
            shift_n    = data;
            idx_n      = '0;
            stop_cnt_n = '0;
            tx_n       = UART_START;
`ifdef UART_TX_PARITY_EN
            par_n      = (^data) ^ PAR_ODD;
`endif
        end else if (tick) begin
            unique case (state)
                START: begin
                    state_n = DATA;
                    tx_n    = shift[0];
                end
                DATA: begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 1'b1;
                    if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = UART_IDLE;
`endif
                    end else begin
                        tx_n = shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_n = STOP;
                    tx_n    = UART_IDLE;
                end
`endif
                STOP: begin
                    stop_cnt_n = stop_cnt + 1'b1;
                    if (stop_cnt == LAST_STOP) begin
                        state_n    = IDLE;
                        stop_cnt_n = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            idx      <= '0;
            stop_cnt <= '0;
            tx       <= UART_IDLE;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            idx      <= idx_n;
            stop_cnt <= stop_cnt_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame tables, serial scoreboard, corners.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = 11 + P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_data = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready, a_tx, a_busy;
    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_tx, b_busy;

    always #5 clk = ~clk;

    uart_tx u_a (
        .clk  (clk),
        .rst  (rst),
        .data (a_data),
        .valid(a_valid),
        .ready(a_ready),
        .tx   (a_tx),
        .busy (a_busy)
    );

    uart_tx #(
        .CLKS_PER_BIT(4),
        .STOP_BITS   (1)
    ) u_b (
        .clk  (clk),
        .rst  (rst),
        .data (b_data),
        .valid(b_valid),
        .ready(b_ready),
        .tx   (b_tx),
        .busy (b_busy)
    );

`ifdef UART_TX_PARITY_EN
    logic [7:0] p_data = 8'h00;
    logic       p_valid = 1'b0;
    logic       pe_ready, pe_tx, pe_busy;
    logic       po_ready, po_tx, po_busy;

    uart_tx #(.PARITY_ODD(0)) u_pe (
        .clk  (clk),
        .rst  (rst),
        .data (p_data),
        .valid(p_valid),
        .ready(pe_ready),
        .tx   (pe_tx),
        .busy (pe_busy)
    );

    uart_tx #(.PARITY_ODD(1)) u_po (
        .clk  (clk),
        .rst  (rst),
        .data (p_data),
        .valid(p_valid),
        .ready(po_ready),
        .tx   (po_tx),
        .busy (po_busy)
    );
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Serial receiver model on u_a: decodes frames and scores them against sb.
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_pos = 0;
        end else if (m_pos == 0) begin
            if (a_tx == 1'b0) m_pos = 1;
        end else begin
            if (m_pos <= 8) m_byte[m_pos-1] = a_tx;
            else if (m_pos >= 9 + P) check("mon_stop", a_tx, 1);
            if (m_pos == 10 + P) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected: got %0h want none", m_byte);
                end else begin
                    check("mon_byte", m_byte, sb.pop_front());
                end
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    typedef struct {
        logic [7:0]  d;
        logic [10:0] fr;
        logic        par;
    } vec_t;

    vec_t vecs[5];

    function automatic logic exp_bit(input logic [10:0] fr, input logic par,
                                     input int i);
        if (P == 1 && i == 9) return par;
        if (P == 1 && i > 9) return fr[10-(i-1)];
        return fr[10-i];
    endfunction

    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        check("ready_pre", a_ready, 1);
        a_data  = d;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(d);
        a_valid = 1'b0;
        a_data  = ~d;
    endtask

    task automatic check_frame_a(input vec_t v);
        for (int i = 0; i < F; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("tx[%0d] of %02h", i, v.d), a_tx,
                  exp_bit(v.fr, v.par, i));
            check($sformatf("busy[%0d] of %02h", i, v.d), a_busy, 1);
        end
        @(negedge clk);
        check("busy_end", a_busy, 0);
        check("tx_idle", a_tx, 1);
        check("ready_idle", a_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v55;
        int   n;

        vecs[0] = '{8'hA5, 11'b0_10100101_11, 1'b0};
        vecs[1] = '{8'h00, 11'b0_00000000_11, 1'b0};
        vecs[2] = '{8'hFF, 11'b0_11111111_11, 1'b0};
        vecs[3] = '{8'h3C, 11'b0_00111100_11, 1'b0};
        vecs[4] = '{8'h01, 11'b0_10000000_11, 1'b1};
        v55     = '{8'h55, 11'b0_10101010_11, 1'b0};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_tx", a_tx, 1);
            check("rst_busy", a_busy, 0);
            check("rst_ready", a_ready, 1);
        end

        foreach (vecs[i]) begin
            send_a(vecs[i].d);
            check_frame_a(vecs[i]);
        end

        // Back-to-back with valid held: second accept in the last stop cycle.
        @(negedge clk);
        check("b2b_ready0", a_ready, 1);
        a_data  = 8'h3C;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(8'h3C);
        a_data = 8'hC3;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_period", n + 1, F);
        check("b2b_busy_at_ready", a_busy, 1);
        @(posedge clk);
        @(negedge clk);
        sb.push_back(8'hC3);
        a_valid = 1'b0;
        check("b2b_no_gap", a_tx, 0);
        check("b2b_busy", a_busy, 1);
        for (int i = 1; i < F; i++) @(negedge clk);
        check("b2b_busy_last", a_busy, 1);
        @(negedge clk);
        check("b2b_busy_end", a_busy, 0);
        @(negedge clk);
        check("b2b_drain", sb.size(), 0);

        // Slow DUT: 4 clocks per bit, one stop bit.
        @(negedge clk);
        check("b_ready0", b_ready, 1);
        b_data  = 8'h01;
        b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        b_data  = 8'hFE;
        for (int j = 0; j < 40 + 4 * P; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("b_tx[%0d]", j), b_tx,
                  (j < 4) ? 0 : (j < 8) ? 1 : (j < 36) ? 0 : 1);
            check($sformatf("b_busy[%0d]", j), b_busy, 1);
        end
        @(negedge clk);
        check("b_busy_end", b_busy, 0);
        check("b_tx_idle", b_tx, 1);
        check("b_ready_end", b_ready, 1);

        // Reset during D3 of 0xFF; valid is already high while rst is high.
        send_a(8'hFF);
        repeat (4) @(negedge clk);
        check("d3_tx", a_tx, 1);
        check("d3_busy", a_busy, 1);
        rst     = 1'b1;
        a_data  = 8'h55;
        a_valid = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_tx", a_tx, 1);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_ready", a_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(8'h55);
        a_valid = 1'b0;
        a_data  = 8'h00;
        check_frame_a(v55);

`ifdef UART_TX_PARITY_EN
        begin
            logic [11:0] fe;
            logic [11:0] fo;
            fe = 12'b0_11100000_1_11;
            fo = 12'b0_11100000_0_11;
            @(negedge clk);
            p_data  = 8'h07;
            p_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            p_valid = 1'b0;
            p_data  = 8'h00;
            for (int i = 0; i < 12; i++) begin
                if (i > 0) @(negedge clk);
                check($sformatf("pe_tx[%0d]", i), pe_tx, fe[11-i]);
                check($sformatf("po_tx[%0d]", i), po_tx, fo[11-i]);
                check($sformatf("pe_busy[%0d]", i), pe_busy, 1);
            end
            @(negedge clk);
            check("pe_busy_end", pe_busy, 0);
            check("po_busy_end", po_busy, 0);
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
